pipeline_hazard_ctrl: RTL and testbench

//  Parametrised hazard controller for the 5-stage RISC-V pipeline, sits beside ID stage.

---
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 117 +++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller beside ID: stalls load-use hazards, flushes IF after taken beq, freezes on mem_busy.
// Latency: hazard outputs are combinational (0 cycles); multi-cycle stall/flush is sequenced by a down-counter.
// Backpressure: mem_busy freezes PC and IF/ID and holds the FSM; optional perf counters via HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_uses_rs2,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic              beq,
  input  logic              zero,
  input  logic              mem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              ctrl_mux_sel,
  output logic              if_flush,
`ifdef HAZ_PERF_CNT_EN
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt,
`endif
  output logic              stall_active
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2
  } state_t;

  // Counter load values: remaining extra cycles after the first (RUN-state) cycle.
  localparam logic [CNT_W-1:0] LU_INIT  = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] BR_INIT  = CNT_W'(BR_FLUSH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_haz, br_tk;
  logic             pc_write_d, if_id_write_d, ctrl_mux_sel_d, if_flush_d;

  // rd==0 is never a real dependency (x0 is hard-wired zero).
  assign lu_haz = id_ex_mem_read && (id_ex_rd != '0) &&
                  ((id_ex_rd == if_id_rs1) || (if_id_uses_rs2 && (id_ex_rd == if_id_rs2)));
  assign br_tk  = beq & zero;

  // State and counter register; reset drops straight back to RUN from any stall/flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode; mem_busy then reset override in that order.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_write_d     = 1'b1;
    if_id_write_d  = 1'b1;
    ctrl_mux_sel_d = 1'b0;
    if_flush_d     = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Load-use wins: the branch operands are not ready, so beq is re-evaluated after the stall.
        if (lu_haz) begin
          pc_write_d     = 1'b0;
          if_id_write_d  = 1'b0;
          ctrl_mux_sel_d = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = ST_LU_STALL;
            cnt_d   = LU_INIT;
          end
        end else if (br_tk) begin
          if_flush_d = 1'b1;
          if (BR_FLUSH > 1) begin
            state_d = ST_BR_FLUSH;
            cnt_d   = BR_INIT;
          end
        end
      end
      ST_LU_STALL: begin
        pc_write_d     = 1'b0;
        if_id_write_d  = 1'b0;
        ctrl_mux_sel_d = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_BR_FLUSH: begin
        if_flush_d = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
    // Memory not ready: freeze everything, capture nothing new.
    if (mem_busy) begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      pc_write_d     = 1'b0;
      if_id_write_d  = 1'b0;
      ctrl_mux_sel_d = 1'b0;
      if_flush_d     = 1'b0;
    end
    // Hold the pipeline quiet with bubbles while reset is asserted.
    if (rst) begin
      pc_write_d     = 1'b0;
      if_id_write_d  = 1'b0;
      ctrl_mux_sel_d = 1'b1;
      if_flush_d     = 1'b0;
    end
  end

  assign pc_write     = pc_write_d;
  assign if_id_write  = if_id_write_d;
  assign ctrl_mux_sel = ctrl_mux_sel_d;
  assign if_flush     = if_flush_d;
  assign stall_active = (state_q != ST_RUN);

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters for bubble cycles and IF flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ctrl_mux_sel_d && !mem_busy && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (if_flush_d && (flush_cnt_q != 16'hFFFF))
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: two controllers share stimulus, A with LOAD_LAT=1/BR_FLUSH=1, B with LOAD_LAT=3/BR_FLUSH=2.
// Each vector is one cycle; outputs packed as {pc_write, if_id_write, ctrl_mux_sel, if_flush, stall_active}.
// Expected values are hand-derived per vector.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       uses_rs2 = 1'b0, mem_read = 1'b0, beq = 1'b0, zero = 1'b0, mem_busy = 1'b0;

  logic a_pw, a_ifw, a_mux, a_fl, a_sa;
  logic b_pw, b_ifw, b_mux, b_fl, b_sa;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int vec_id   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_FLUSH(1), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(uses_rs2),
    .id_ex_rd(rd), .id_ex_mem_read(mem_read), .beq(beq), .zero(zero), .mem_busy(mem_busy),
    .pc_write(a_pw), .if_id_write(a_ifw), .ctrl_mux_sel(a_mux), .if_flush(a_fl),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt),
`endif
    .stall_active(a_sa)
  );

  pipeline_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_FLUSH(2), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst),
    .if_id_rs1(rs1), .if_id_rs2(rs2), .if_id_uses_rs2(uses_rs2),
    .id_ex_rd(rd), .id_ex_mem_read(mem_read), .beq(beq), .zero(zero), .mem_busy(mem_busy),
    .pc_write(b_pw), .if_id_write(b_ifw), .ctrl_mux_sel(b_mux), .if_flush(b_fl),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt),
`endif
    .stall_active(b_sa)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one cycle of inputs, check both controllers mid-cycle, then advance past the edge.
  task automatic apply(input logic r, input logic [4:0] s1, input logic [4:0] s2, input logic u,
                       input logic [4:0] d, input logic mr, input logic bq, input logic z,
                       input logic bz, input logic [4:0] exp_a, input logic [4:0] exp_b);
    vec_id++;
    rst = r; rs1 = s1; rs2 = s2; uses_rs2 = u; rd = d;
    mem_read = mr; beq = bq; zero = z; mem_busy = bz;
    #2;
    check($sformatf("v%0d_A", vec_id), {11'd0, a_pw, a_ifw, a_mux, a_fl, a_sa}, {11'd0, exp_a});
    check($sformatf("v%0d_B", vec_id), {11'd0, b_pw, b_ifw, b_mux, b_fl, b_sa}, {11'd0, exp_b});
    @(posedge clk);
    #1;
  endtask

  initial begin
    //     rst rs1 rs2 u  rd  mr beq z  busy  A          B
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 5'b00100); // in reset
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000); // idle run
    apply(0, 1, 2, 1, 3, 1, 0, 0, 0, 5'b11000, 5'b11000); // load, no dependency
    apply(0, 1, 2, 1, 1, 1, 0, 0, 0, 5'b00100, 5'b00100); // rd==rs1 load-use
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101); // B stall cycle 2
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101); // B stall cycle 3
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000);
    apply(0, 1, 5, 1, 5, 1, 0, 0, 0, 5'b00100, 5'b00100); // rd==rs2 with uses_rs2
    apply(0, 1, 5, 1, 5, 1, 0, 0, 0, 5'b00100, 5'b00101); // B ignores hazard in LU_STALL
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000);
    apply(0, 1, 5, 0, 5, 1, 0, 0, 0, 5'b11000, 5'b11000); // rs2 unused: no stall
    apply(0, 0, 0, 1, 0, 1, 0, 0, 0, 5'b11000, 5'b11000); // rd==0: no stall
    apply(0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11010, 5'b11010); // taken beq
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11011); // B second flush cycle
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000);
    apply(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b11000, 5'b11000); // beq not taken
    apply(0, 1, 0, 0, 1, 1, 1, 1, 0, 5'b00100, 5'b00100); // load-use beats taken beq
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000);
    apply(0, 1, 0, 0, 1, 1, 0, 0, 0, 5'b00100, 5'b00100); // load-use, then freeze
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00001); // mem_busy holds LU_STALL
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00001);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101); // stall resumes, extended by 2
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000);
    apply(0, 1, 0, 0, 1, 1, 0, 0, 1, 5'b00000, 5'b00000); // hazard under busy: not captured
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000);
    apply(0, 1, 0, 0, 1, 1, 0, 0, 0, 5'b00100, 5'b00100);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101);
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 5'b00100); // reset mid-stall
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000); // back in RUN after release
    apply(0, 1, 0, 0, 1, 1, 0, 0, 0, 5'b00100, 5'b00100); // one load-use for counters
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b00101);
    apply(0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11010, 5'b11010); // one taken beq
    apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 5'b00001); // busy holds BR_FLUSH
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11011);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000, 5'b11000);
`ifdef HAZ_PERF_CNT_EN
    check("perf_stall_A", a_stall_cnt, 16'd1);
    check("perf_flush_A", a_flush_cnt, 16'd1);
    check("perf_stall_B", b_stall_cnt, 16'd3);
    check("perf_flush_B", b_flush_cnt, 16'd2);
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
